// File: rtl/button_event_queue_if.sv
// Valid/ready event channel from the button event queue to the game controller.
interface button_event_queue_if;
  logic       ev_valid;
  logic       ev_ready;
  logic [1:0] ev_code;
  logic       ev_long;

  modport master (output ev_valid, output ev_code, output ev_long, input ev_ready);
  modport slave  (input ev_valid, input ev_code, input ev_long, output ev_ready);
endinterface

// File: rtl/button_event_queue.sv
// Turns single-button press/release cycles into colour events (code + long flag),
// rejects chords and queues events in a small FIFO behind a valid/ready handshake.
module button_event_queue #(
  parameter int unsigned LONG_CYCLES = 50_000_000,
  parameter int unsigned CNT_W       = 26,
  parameter int unsigned DEPTH       = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [3:0]           btn,
  button_event_queue_if.master ev,
  output logic                 busy,
  output logic                 reject,
  output logic                 overflow
);

  localparam int unsigned      AW       = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] LONG_MAX = CNT_W'(LONG_CYCLES);

  typedef enum logic [1:0] {IDLE, PRESSED, RELEASE_WAIT} state_t;

  state_t           state;
  state_t           next_state;
  logic [3:0]       btn_q;
  logic             btn_q_valid;
  logic [1:0]       code;
  logic [1:0]       btn_code;
  logic [CNT_W-1:0] hold_cnt;
  logic [2:0]       mem [DEPTH];
  logic [2:0]       head;
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             onehot;
  logic             is_clear;
  logic             is_held;
  logic             empty;
  logic             full;
  logic             pop;
  logic             push;
  logic             push_req;
  logic             start_press;
  logic             reject_set;
  logic             overflow_set;

  assign onehot   = (btn_q != 4'b0000) && ((btn_q & (btn_q - 4'd1)) == 4'b0000);
  assign is_clear = (btn_q == 4'b0000);
  assign is_held  = (btn_q == (4'b0001 << code));
  assign btn_code = {btn_q[3] | btn_q[2], btn_q[3] | btn_q[1]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= RELEASE_WAIT;
    else      state <= next_state;
  end

  // btn_q reads as zero right after reset; btn_q_valid keeps a button held
  // through reset from being mistaken for a release.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (onehot)         next_state = PRESSED;
        else if (!is_clear) next_state = RELEASE_WAIT;
      end
      PRESSED: begin
        if (is_clear)       next_state = IDLE;
        else if (!is_held)  next_state = RELEASE_WAIT;
      end
      RELEASE_WAIT: begin
        if (is_clear && btn_q_valid) next_state = IDLE;
      end
      default: next_state = RELEASE_WAIT;
    endcase
  end

  always_comb begin
    busy        = (state == PRESSED);
    start_press = (state == IDLE) && onehot;
    push_req    = (state == PRESSED) && is_clear;
    reject_set  = ((state == IDLE) && !is_clear && !onehot) ||
                  ((state == PRESSED) && !is_clear && !is_held);
  end

  assign empty        = (wr_ptr == rd_ptr);
  assign full         = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop          = !empty && ev.ev_ready;
  assign push         = push_req && (!full || pop);
  assign overflow_set = push_req && full && !pop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btn_q       <= 4'b0000;
      btn_q_valid <= 1'b0;
      code        <= 2'd0;
      hold_cnt    <= '0;
      reject      <= 1'b0;
      overflow    <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else begin
      btn_q       <= btn;
      btn_q_valid <= 1'b1;
      reject      <= reject_set;
      overflow    <= overflow_set;
      if (start_press) begin
        code     <= btn_code;
        hold_cnt <= '0;
      end else if ((state == PRESSED) && is_held && (hold_cnt < LONG_MAX)) begin
        hold_cnt <= hold_cnt + 1'b1;
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // A push into a full FIFO with a concurrent pop reuses the slot being vacated.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {code, (hold_cnt >= LONG_MAX)};
  end

  assign head        = mem[rd_ptr[AW-1:0]];
  assign ev.ev_valid = !empty;
  assign ev.ev_code  = empty ? 2'd0 : head[2:1];
  assign ev.ev_long  = !empty && head[0];

endmodule

// File: tb/tb_button_event_queue.sv
// Directed bench for button_event_queue with LONG_CYCLES=8 and DEPTH=4.
module tb_button_event_queue;

  localparam int unsigned LONG_CYCLES = 8;
  localparam int unsigned CNT_W       = 4;
  localparam int unsigned DEPTH       = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] btn;
  logic       busy;
  logic       reject;
  logic       overflow;

  int checks        = 0;
  int errors        = 0;
  int reject_seen   = 0;
  int overflow_seen = 0;
  int base_rej;
  int base_ovf;

  button_event_queue_if ev_if();

  button_event_queue #(
    .LONG_CYCLES(LONG_CYCLES),
    .CNT_W      (CNT_W),
    .DEPTH      (DEPTH)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .btn     (btn),
    .ev      (ev_if),
    .busy    (busy),
    .reject  (reject),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reject)   reject_seen++;
    if (overflow) overflow_seen++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] pattern, input int cycles);
    btn = pattern;
    repeat (cycles) tick();
  endtask

  // Hold one button, release it and wait until the event has been pushed.
  task automatic pressRelease(input logic [1:0] c, input int hold);
    applyStimulus(4'b0001 << c, hold);
    btn = 4'b0000;
    tick();
    tick();
  endtask

  task automatic popHead(input logic [1:0] exp_code, input logic exp_long, input string tag);
    checkOutput({tag, "_valid"}, 32'(ev_if.ev_valid), 32'd1);
    checkOutput({tag, "_code"},  32'(ev_if.ev_code),  32'(exp_code));
    checkOutput({tag, "_long"},  32'(ev_if.ev_long),  32'(exp_long));
    ev_if.ev_ready = 1'b1;
    tick();
    ev_if.ev_ready = 1'b0;
  endtask

  initial begin
    rst            = 1'b0;
    btn            = 4'b0000;
    ev_if.ev_ready = 1'b0;
    repeat (3) tick();
    checkOutput("rst_valid",    32'(ev_if.ev_valid), 32'd0);
    checkOutput("rst_code",     32'(ev_if.ev_code),  32'd0);
    checkOutput("rst_long",     32'(ev_if.ev_long),  32'd0);
    checkOutput("rst_busy",     32'(busy),           32'd0);
    checkOutput("rst_reject",   32'(reject),         32'd0);
    checkOutput("rst_overflow", 32'(overflow),       32'd0);
    rst = 1'b1;
    repeat (3) tick();
    checkOutput("idle_busy", 32'(busy), 32'd0);

    // Short press with the consumer always ready.
    ev_if.ev_ready = 1'b1;
    applyStimulus(4'b0100, 3);
    checkOutput("short_busy", 32'(busy), 32'd1);
    btn = 4'b0000;
    tick();
    checkOutput("short_valid_early", 32'(ev_if.ev_valid), 32'd0);
    tick();
    checkOutput("short_valid", 32'(ev_if.ev_valid), 32'd1);
    checkOutput("short_code",  32'(ev_if.ev_code),  32'd2);
    checkOutput("short_long",  32'(ev_if.ev_long),  32'd0);
    checkOutput("short_busy_done", 32'(busy), 32'd0);
    tick();
    checkOutput("short_popped", 32'(ev_if.ev_valid), 32'd0);
    ev_if.ev_ready = 1'b0;

    // Long-press threshold.
    pressRelease(2'd0, 20);
    popHead(2'd0, 1'b1, "hold20");
    pressRelease(2'd3, 9);
    popHead(2'd3, 1'b1, "hold9");
    pressRelease(2'd1, 8);
    popHead(2'd1, 1'b0, "hold8");
    checkOutput("long_drained", 32'(ev_if.ev_valid), 32'd0);

    // Chord while a press is in progress.
    base_rej = reject_seen;
    applyStimulus(4'b0010, 3);
    checkOutput("chord_busy_single", 32'(busy), 32'd1);
    applyStimulus(4'b0011, 1);
    checkOutput("chord_busy_held", 32'(busy), 32'd1);
    tick();
    checkOutput("chord_reject", 32'(reject), 32'd1);
    checkOutput("chord_busy_fall", 32'(busy), 32'd0);
    tick();
    checkOutput("chord_reject_end", 32'(reject), 32'd0);
    applyStimulus(4'b0000, 4);
    checkOutput("chord_reject_count", 32'(reject_seen - base_rej), 32'd1);
    checkOutput("chord_no_event", 32'(ev_if.ev_valid), 32'd0);

    // Chord straight from IDLE.
    base_rej = reject_seen;
    applyStimulus(4'b0011, 1);
    checkOutput("idle_chord_early", 32'(reject), 32'd0);
    tick();
    checkOutput("idle_chord_reject", 32'(reject), 32'd1);
    checkOutput("idle_chord_busy", 32'(busy), 32'd0);
    applyStimulus(4'b0000, 4);
    checkOutput("idle_chord_count", 32'(reject_seen - base_rej), 32'd1);
    checkOutput("idle_chord_no_event", 32'(ev_if.ev_valid), 32'd0);

    // Overflow: fifth event is dropped.
    base_ovf = overflow_seen;
    pressRelease(2'd0, 2);
    pressRelease(2'd1, 2);
    pressRelease(2'd2, 2);
    pressRelease(2'd3, 2);
    checkOutput("fill_no_overflow", 32'(overflow_seen - base_ovf), 32'd0);
    pressRelease(2'd0, 2);
    checkOutput("ovf_pulse", 32'(overflow), 32'd1);
    tick();
    checkOutput("ovf_pulse_end", 32'(overflow), 32'd0);
    checkOutput("ovf_count", 32'(overflow_seen - base_ovf), 32'd1);
    popHead(2'd0, 1'b0, "drain0");
    popHead(2'd1, 1'b0, "drain1");
    popHead(2'd2, 1'b0, "drain2");
    popHead(2'd3, 1'b0, "drain3");
    checkOutput("drain_empty", 32'(ev_if.ev_valid), 32'd0);

    // Full FIFO with a pop on the push edge.
    pressRelease(2'd1, 2);
    pressRelease(2'd2, 2);
    pressRelease(2'd3, 2);
    pressRelease(2'd0, 2);
    base_ovf = overflow_seen;
    applyStimulus(4'b1000, 2);
    btn = 4'b0000;
    tick();
    ev_if.ev_ready = 1'b1;
    tick();
    ev_if.ev_ready = 1'b0;
    checkOutput("fullpop_no_ovf", 32'(overflow), 32'd0);
    popHead(2'd2, 1'b0, "fullpop0");
    popHead(2'd3, 1'b0, "fullpop1");
    popHead(2'd0, 1'b0, "fullpop2");
    popHead(2'd3, 1'b0, "fullpop3");
    checkOutput("fullpop_empty", 32'(ev_if.ev_valid), 32'd0);
    checkOutput("fullpop_ovf_count", 32'(overflow_seen - base_ovf), 32'd0);

    // Reset in the middle of a press with events queued.
    pressRelease(2'd1, 2);
    pressRelease(2'd2, 2);
    checkOutput("pre_rst_valid", 32'(ev_if.ev_valid), 32'd1);
    applyStimulus(4'b1000, 3);
    checkOutput("pre_rst_busy", 32'(busy), 32'd1);
    base_rej = reject_seen;
    rst = 1'b0;
    #1;
    checkOutput("mid_rst_valid", 32'(ev_if.ev_valid), 32'd0);
    checkOutput("mid_rst_busy",  32'(busy),           32'd0);
    checkOutput("mid_rst_code",  32'(ev_if.ev_code),  32'd0);
    tick();
    tick();
    rst = 1'b1;
    repeat (4) tick();
    checkOutput("held_thru_rst_busy", 32'(busy), 32'd0);
    btn = 4'b0000;
    repeat (4) tick();
    checkOutput("held_thru_rst_no_event",  32'(ev_if.ev_valid), 32'd0);
    checkOutput("held_thru_rst_no_reject", 32'(reject_seen - base_rej), 32'd0);
    pressRelease(2'd0, 3);
    popHead(2'd0, 1'b0, "post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/button_event_queue.md
Name: button_event_queue

Overview:
- Sits directly downstream of the per-button debouncers in the Simon input path.
- Takes four clean, debounced button levels and converts each complete press-and-release of exactly one button into a colour event: a 2-bit code plus a long-press flag.
- Events are queued in a small FIFO and handed to the game controller over a valid/ready handshake.
- Chords (overlapping presses) are rejected and reported.

Parameters:
- LONG_CYCLES, 50_000_000: hold duration in clk cycles at or above which a press is flagged long (0.5 s at 100 MHz).
- CNT_W, 26: width of the hold counter. Must satisfy 2^CNT_W > LONG_CYCLES.
- DEPTH, 4: FIFO entries. Must be a power of 2 and at least 2.

Ports:
- clk  in  1  100 MHz system clock.
- rst  in  1  asynchronous, active-low reset. Asserted when 0.
- btn  in  4  debounced button levels, active-high. Bit i maps to colour code i.
- ev_valid  out  1  FIFO non-empty; head event is presented.
- ev_ready  in  1  consumer accepts the head event when ev_valid && ev_ready at a rising edge.
- ev_code  out  2  colour code of the head event.
- ev_long  out  1  long-press flag of the head event.
- busy  out  1  high while state is PRESSED.
- reject  out  1  one-cycle pulse when a press is rejected as a chord.
- overflow  out  1  one-cycle pulse when an event is dropped because the FIFO is full.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=RELEASE_WAIT, btn_q=0000, hold counter=0.
  - FIFO empty: read and write pointers 0.
  - ev_valid=0, ev_code=0, ev_long=0, busy=0, reject=0, overflow=0.
- Input register:
  - btn is registered once per clk into btn_q.
  - The FSM acts on btn_q only.
- FSM states:
  - IDLE:
    - btn_q one-hot with bit i → PRESSED; latch code=i; clear hold counter.
    - btn_q multi-hot → RELEASE_WAIT; pulse reject.
    - btn_q=0000 → stay.
  - PRESSED:
    - Hold counter increments each cycle and saturates at LONG_CYCLES.
    - btn_q equal to the latched one-hot → stay.
    - btn_q=0000 → push {code, long = (counter >= LONG_CYCLES)} to the FIFO; → IDLE.
    - Any other btn_q value (extra bit set, or a different single bit) → RELEASE_WAIT; pulse reject; no event.
  - RELEASE_WAIT:
    - Stay until btn_q=0000, then → IDLE.
    - No reject pulse when this state is entered from reset.
- Reset-state consequence: a button held through reset deassertion produces no event and no reject.
- Latency:
  - btn falls at edge k and is captured in btn_q at edge k.
  - The push occurs at edge k+1.
  - ev_valid is high after edge k+1.
- Hold-count reference: a press whose btn_q is one-hot for exactly N cycles ends PRESSED with counter = min(N-1, LONG_CYCLES).
- FIFO:
  - ev_valid = !empty. ev_code and ev_long come from the head entry.
  - Head outputs are stable while ev_valid && !ev_ready.
  - A pop occurs on ev_valid && ev_ready.
  - Push while full with no pop: event dropped, overflow pulses, FIFO contents unchanged.
  - Push while full with a simultaneous pop: the push is accepted, occupancy is unchanged, no overflow.
  - Push and pop on empty cannot coincide, because ev_valid=0.
  - Pointers are log2(DEPTH)+1 bits wide and wrap naturally.
  - Full condition: pointer MSBs differ and the lower bits are equal.
  - ev_ready while empty is ignored.
- Outputs:
  - busy = (state==PRESSED).
  - reject and overflow are registered and high for exactly one cycle per event.
- Mid-operation reset: any state immediately → RELEASE_WAIT; queued events are discarded.

Test Plan:
- Bench uses LONG_CYCLES=8, DEPTH=4.
- Short press: btn=0100 for 3 cycles then 0000, ev_ready=1 → ev_valid rises 2 edges after the release sample; ev_code=2, ev_long=0; pops next edge, ev_valid=0.
- Long press: btn=0001 for 20 cycles then 0000 → ev_code=0, ev_long=1. A hold of 9 cycles → ev_long=1; a hold of 8 cycles → ev_long=0.
- Chord: btn=0010, then 0011, then 0000 → reject pulses once, no event queued, busy falls. btn=0011 from IDLE → reject, no event.
- Overflow: ev_ready=0, five short presses with codes 0,1,2,3,0 → fifth press pulses overflow; draining yields 0,1,2,3 in order, then ev_valid=0.
- Full plus simultaneous pop: FIFO full, ev_ready=1 on the push cycle → no overflow; occupancy stays 4; the new event appears last.
- Reset: assert rst=0 while btn=1000 is held with 2 events queued → ev_valid=0 at once. Release rst while btn is still held, then release btn → no event, no reject. Next press of 0001 → ev_code=0.
